// File: rtl/lfsr_pkg.sv
// Shared definitions for the Galois LFSR generator and its checker.
package lfsr_pkg;

  localparam logic [15:0] LFSR_TAPS_DEFAULT = 16'b0000_0000_0001_1101;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lfsr_state_t;

  // Width-generic Galois step; words up to 64 bits, result masked to nbits.
  function automatic logic [63:0] lfsr_next(input logic [63:0] x,
                                            input logic [63:0] taps,
                                            input int unsigned nbits,
                                            input logic        invert);
    logic [63:0] mask;
    logic [63:0] shifted;
    logic        msb;
    mask    = (nbits >= 64) ? '1 : ((64'd1 << nbits) - 64'd1);
    msb     = |(x & (64'd1 << (nbits - 1)));
    shifted = {x[62:0], 1'b0};
    return (shifted ^ ((msb ^ invert) ? taps : '0)) & mask;
  endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Checks a sampled Galois LFSR word stream: locks after consecutive good
// transitions, counts mismatches while locked, drops lock on a bad run.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter            TAPS       = LFSR_TAPS_DEFAULT,
  parameter int        INVERT     = 0,
  parameter int        LOCK_COUNT = 4,
  parameter int        LOSS_COUNT = 3,
  parameter int        CNT_W      = 16,
  localparam int       NBITS      = $bits(TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [NBITS-1:0] lfsr_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic             zero_seen
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);

  lfsr_state_t      state;
  logic [NBITS-1:0] prev;
  logic             have_prev;
  logic [GW-1:0]    good_run;
  logic [LW-1:0]    bad_run;

  logic [NBITS-1:0] expected;
  logic             zero_word;
  logic             sample;
  logic             good;
  logic             bad;
  logic             err_inc;

  assign expected  = NBITS'(lfsr_next(64'(prev), 64'(TAPS), NBITS, (INVERT != 0)));
  assign zero_word = (lfsr_in == '0);
  assign sample    = in_valid && !clear;
  // All-zero is the lock-up word of a non-inverted LFSR, so it never counts as good.
  assign good      = have_prev && (lfsr_in == expected) && !(zero_word && (INVERT == 0));
  assign bad       = have_prev && !good;
  assign err_inc   = sample && bad && (state == LOCKED);
  assign locked    = (state == LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      prev      <= '0;
      have_prev <= 1'b0;
      good_run  <= '0;
      bad_run   <= '0;
      err_pulse <= 1'b0;
      zero_seen <= 1'b0;
    end else if (clear) begin
      state     <= HUNT;
      have_prev <= 1'b0;
      good_run  <= '0;
      bad_run   <= '0;
      err_pulse <= 1'b0;
      zero_seen <= 1'b0;
    end else begin
      err_pulse <= err_inc;
      if (sample) begin
        prev      <= lfsr_in;
        have_prev <= 1'b1;
        if (zero_word) zero_seen <= 1'b1;
        case (state)
          HUNT: begin
            if (good) begin
              good_run <= good_run + 1'b1;
              if (good_run == GW'(LOCK_COUNT - 1)) begin
                state   <= LOCKED;
                bad_run <= '0;
              end
            end else if (bad) begin
              good_run <= '0;
            end
          end
          LOCKED: begin
            if (good) begin
              bad_run <= '0;
            end else if (bad) begin
              bad_run <= bad_run + 1'b1;
              if (bad_run == LW'(LOSS_COUNT - 1)) begin
                state    <= HUNT;
                good_run <= '0;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_err_count (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (clear),
    .count (err_count)
  );

  sat_counter #(.W(CNT_W)) u_word_count (
    .clk   (clk),
    .reset (reset),
    .inc   (sample),
    .clr   (clear),
    .count (word_count)
  );

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter TAPS, default 16'b_00000000_00011101; Galois tap mask; width NBITS derived from it.
REQ-002 SHALL have parameter INVERT, default 0; feedback inversion, matching the upstream generator.
REQ-003 SHALL have parameter LOCK_COUNT, default 4; consecutive good transitions needed to lock (at least 1).
REQ-004 SHALL have parameter LOSS_COUNT, default 3; consecutive bad transitions that drop lock (at least 1).
REQ-005 SHALL have parameter CNT_W, default 16; counter width.
REQ-006 SHALL have port clk, input, 1 bit; the single clock.
REQ-007 SHALL have port reset, input, 1 bit; asynchronous, active-high.
REQ-008 SHALL have port clear, input, 1 bit; synchronous restart of FSM and counters.
REQ-009 SHALL have port in_valid, input, 1 bit; lfsr_in is sampled this cycle (the generator's enable).
REQ-010 SHALL have port lfsr_in, input, NBITS; generator register word.
REQ-011 SHALL have port locked, output, 1 bit; FSM is in LOCKED.
REQ-012 SHALL have port err_pulse, output, 1 bit; one-cycle pulse per mismatch counted while LOCKED.
REQ-013 SHALL have port err_count, output, CNT_W; saturating mismatch count.
REQ-014 SHALL have port word_count, output, CNT_W; saturating count of sampled words.
REQ-015 SHALL have port zero_seen, output, 1 bit; sticky flag, all-zero word sampled.

Function
REQ-016 SHALL define next(x) as {x[NBITS-2:0],0} XOR ((x[NBITS-1] XOR INVERT) ? TAPS : 0).
REQ-017 SHALL hold prev (NBITS) and have_prev; every sampled word loads prev; have_prev SHALL be set on the first sample.
REQ-018 A sample with have_prev=0 SHALL be neither good nor bad.
REQ-019 A sample with have_prev=1 SHALL be good iff lfsr_in == next(prev), else bad.
REQ-020 An all-zero lfsr_in with INVERT=0 SHALL be bad regardless of prev.
REQ-021 FSM states SHALL be HUNT and LOCKED; reset state HUNT.
REQ-022 In HUNT: good increments good_run; bad sets good_run to 0.
REQ-023 In HUNT: when good_run reaches LOCK_COUNT, the FSM SHALL go to LOCKED and clear bad_run.
REQ-024 In LOCKED: good sets bad_run to 0.
REQ-025 In LOCKED: bad SHALL increment bad_run and err_count (saturating) and assert err_pulse.
REQ-026 In LOCKED: when bad_run reaches LOSS_COUNT, the FSM SHALL go to HUNT, clear good_run and keep prev.
REQ-027 Bad samples in HUNT SHALL NOT affect err_count or err_pulse.
REQ-028 word_count SHALL increment on each sample, saturating at all-ones.
REQ-029 zero_seen SHALL set on any all-zero sample and clear only on reset or clear.
REQ-030 All outputs SHALL be registered and reflect a sample on the cycle after the in_valid edge; cycles with in_valid=0 SHALL change nothing.
REQ-031 clear SHALL take priority over a simultaneous in_valid: that sample is discarded.
REQ-032 clear SHALL return to HUNT, zero all counters, good_run, bad_run and have_prev, and clear zero_seen.
REQ-033 Saturated counters SHALL hold at all-ones; err_pulse SHALL still fire.

Reset
REQ-034 Asserting reset SHALL immediately set state HUNT, prev=0, have_prev=0, good_run=0 and bad_run=0.
REQ-035 Asserting reset SHALL immediately set locked=0, err_pulse=0, err_count=0, word_count=0 and zero_seen=0.
REQ-036 Reset mid-run SHALL discard all history; the first sample after release SHALL only seed prev.

Structure
REQ-037 A shared package lfsr_pkg SHALL hold the default TAPS constant, the next() function and the FSM state enum, for use by the generator and this checker.
REQ-038 The block SHALL instantiate one sub-module, sat_counter (parameter W, ports inc, clr, count), for err_count and word_count.

Verification (TAPS=16'h001D, INVERT=0)
REQ-039 Lock: drive the generator from reset, 5 valid words -> locked=1 one cycle after the 5th sample; err_count=0; word_count=5.
REQ-040 Prediction: words 16'h8000 then 16'h001D -> counted good; words 16'h0001 then 16'h0003 -> counted bad.
REQ-041 Error: once locked, corrupt 1 word -> err_pulse on 2 cycles (corrupt sample and the next transition); err_count=2; locked stays 1.
REQ-042 Loss: once locked, 3 consecutive bad samples -> locked=0 after the 3rd; 4 further good samples -> locked=1 again.
REQ-043 Zero: sample 16'h0000 -> zero_seen=1 and counted as bad; clear in the same cycle as in_valid -> sample ignored and all counters 0.
REQ-044 Async reset between clock edges while locked -> outputs zero immediately, without a clock edge.
